// File: rtl/pipe_in_mem_player.sv
// pipe_in_mem_player
// Loads a DEPTH-entry table of 32-bit samples from a 16-bit host pipe-in
// stream, low half first. Once the table is full, it replays the table one
// sample per sample_tick, either one-shot or looped.
//
// Ports:
//   pipe_clk       sole clock
//   reset1         synchronous active-high reset
//   pipe_in_write  host half-word strobe
//   pipe_in_data   host half-word
//   play_start     begin playback from sample 0 (READY/DONE only)
//   loop_en        wrap after the last sample instead of stopping
//   sample_tick    one playback step
//   play_data      current sample, held between ticks
//   play_valid     play_data updated this cycle
//   load_complete  table fully loaded
//   playing        in PLAY
//   overrun        sticky: a pipe-in write arrived after loading finished
module pipe_in_mem_player #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = 10
) (
    input  logic        pipe_clk,
    input  logic        reset1,
    input  logic        pipe_in_write,
    input  logic [15:0] pipe_in_data,
    input  logic        play_start,
    input  logic        loop_en,
    input  logic        sample_tick,
    output logic [31:0] play_data,
    output logic        play_valid,
    output logic        load_complete,
    output logic        playing,
    output logic        overrun
);

    typedef enum logic [1:0] {StLoad, StReady, StPlay, StDone} state_e;

    localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);

    state_e          r_state;
    state_e          w_state_next;
    logic            r_half;
    logic [15:0]     r_hold;
    logic [AW-1:0]   r_wr_index;
    logic [AW-1:0]   r_rd_index;
    logic [31:0]     r_mem [DEPTH];
    logic [31:0]     r_play_data;
    logic            r_play_valid;
    logic            r_overrun;

    logic            w_load_wr;
    logic            w_last_wr;
    logic            w_start;
    logic            w_play_tick;
    logic            w_last_rd;

    // Second half of a pair commits a full word to the table.
    assign w_load_wr   = (r_state == StLoad) && pipe_in_write && r_half;
    assign w_last_wr   = w_load_wr && (r_wr_index == LastIdx);
    // Start wins over a simultaneous tick: ticks only count once in PLAY.
    assign w_start     = ((r_state == StReady) || (r_state == StDone)) && play_start;
    assign w_play_tick = (r_state == StPlay) && sample_tick;
    assign w_last_rd   = w_play_tick && (r_rd_index == LastIdx);

    // State register
    always_ff @(posedge pipe_clk) begin
        if (reset1) begin
            r_state <= StLoad;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StLoad:  if (w_last_wr) w_state_next = StReady;
            StReady: if (play_start) w_state_next = StPlay;
            StPlay:  if (w_last_rd && !loop_en) w_state_next = StDone;
            StDone:  if (play_start) w_state_next = StPlay;
            default: w_state_next = StLoad;
        endcase
    end

    // Output logic
    always_comb begin
        load_complete = (r_state != StLoad);
        playing       = (r_state == StPlay);
        play_data     = r_play_data;
        play_valid    = r_play_valid;
        overrun       = r_overrun;
    end

    // Load/playback datapath
    always_ff @(posedge pipe_clk) begin
        if (reset1) begin
            r_half       <= 1'b0;
            r_hold       <= 16'h0000;
            r_wr_index   <= '0;
            r_rd_index   <= '0;
            r_play_data  <= 32'h0000_0000;
            r_play_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_play_valid <= 1'b0;
            if (pipe_in_write) begin
                if (r_state == StLoad) begin
                    r_half <= ~r_half;
                    if (!r_half) begin
                        r_hold <= pipe_in_data;
                    end else begin
                        r_wr_index <= r_wr_index + AW'(1);
                    end
                end else begin
                    r_overrun <= 1'b1;
                end
            end
            if (w_start) begin
                r_rd_index <= '0;
            end else if (w_play_tick) begin
                r_play_data  <= r_mem[r_rd_index];
                r_play_valid <= 1'b1;
                r_rd_index   <= w_last_rd ? '0 : r_rd_index + AW'(1);
            end
        end
    end

    // Table storage is deliberately not reset; a full reload redefines it.
    always_ff @(posedge pipe_clk) begin
        if (w_load_wr) begin
            r_mem[r_wr_index] <= {pipe_in_data, r_hold};
        end
    end

endmodule
